// File: rtl/shift_ring_controller_pkg.sv
// Shared types for the shift-ring controller: FSM states and rotation direction.
package shift_ring_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        FWD = 1'b0,
        BWD = 1'b1
    } dir_e;

endpackage

// File: rtl/shift_ring_controller_if.sv
// Request/response bus of the shift-ring controller; master = requester, slave = controller.
interface shift_ring_controller_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/shift_ring_controller_ring_step_counter.sv
// Loadable down-counter of remaining shift cycles; 'last' flags the final shift cycle.
module ring_step_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             last
);
    logic [WIDTH-1:0] count_q, count_d;

    // Next count: load wins, otherwise decrement while enabled and non-zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == WIDTH'(1));
endmodule

// File: rtl/shift_ring_controller.sv
// Shift-ring memory controller: words sit in a rotating flop ring and are accessed at the head slot.
// Build macro SHIFT_RING_BIDIR_EN adds backward rotation along the shorter path.
module shift_ring_controller
    import shift_ring_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    parameter  int LANES      = 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    shift_ring_controller_if.slave bus,
    output logic [DATA_WIDTH-1:0]  head,
    output logic [ADDR_WIDTH-1:0]  cursor,
    output logic                   busy
);
    localparam int WORD_SHIFTS = DATA_WIDTH / LANES;
    localparam int RING_BITS   = DEPTH * DATA_WIDTH;
    localparam int CNT_W       = $clog2(DEPTH * WORD_SHIFTS);
    localparam int LANE_W      = (WORD_SHIFTS > 1) ? $clog2(WORD_SHIFTS) : 1;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [RING_BITS-1:0]  ring_q, ring_d;
    logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  accept_s;
    logic [ADDR_WIDTH-1:0] steps_s, words_s, cursor_next_s;
    logic [CNT_W-1:0]      shift_count_s;
    logic [RING_BITS-1:0]  ring_fwd_s, ring_next_s;
    logic                  cnt_load_s, cnt_en_s, cnt_last_s;

    assign accept_s      = (state_q == IDLE) && bus.req_valid;
    assign steps_s       = bus.req_addr - cursor_q;
    assign ring_fwd_s    = {ring_q[LANES-1:0], ring_q[RING_BITS-1:LANES]};
    assign shift_count_s = CNT_W'(words_s) * CNT_W'(WORD_SHIFTS);

`ifdef SHIFT_RING_BIDIR_EN
    localparam logic [ADDR_WIDTH-1:0] HALF_WAY = ADDR_WIDTH'(DEPTH / 2);

    dir_e                 dir_q, dir_d, dir_sel_s;
    logic [RING_BITS-1:0] ring_bwd_s;

    assign ring_bwd_s = {ring_q[RING_BITS-LANES-1:0], ring_q[RING_BITS-1:RING_BITS-LANES]};

    // Shorter way round wins; an exact half turn still goes forward
    always_comb begin
        dir_sel_s     = (steps_s > HALF_WAY) ? BWD : FWD;
        words_s       = (dir_sel_s == BWD) ? (ADDR_WIDTH'(0) - steps_s) : steps_s;
        dir_d         = accept_s ? dir_sel_s : dir_q;
        ring_next_s   = (dir_q == BWD) ? ring_bwd_s : ring_fwd_s;
        cursor_next_s = (dir_q == BWD) ? (cursor_q - ADDR_WIDTH'(1)) : (cursor_q + ADDR_WIDTH'(1));
    end

    // Rotation direction latched at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= FWD;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Forward-only rotation
    always_comb begin
        words_s       = steps_s;
        ring_next_s   = ring_fwd_s;
        cursor_next_s = cursor_q + ADDR_WIDTH'(1);
    end
`endif

    ring_step_counter #(.WIDTH(CNT_W)) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load_s),
        .en         (cnt_en_s),
        .load_value (shift_count_s),
        .last       (cnt_last_s)
    );

    // FSM next state, ring rotation and response capture
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        ring_d      = ring_q;
        cursor_d    = cursor_q;
        lane_d      = lane_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_load_s  = 1'b0;
        cnt_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    write_d    = bus.req_write;
                    wdata_d    = bus.req_wdata;
                    lane_d     = '0;
                    cnt_load_s = 1'b1;
                    if (shift_count_s == '0) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ring_q[DATA_WIDTH-1:0];
                        ring_d      = bus.req_write ? {ring_q[RING_BITS-1:DATA_WIDTH], bus.req_wdata} : ring_q;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                cnt_en_s = 1'b1;
                // The cursor moves only once a whole word has passed the head slot
                if (lane_q == LANE_W'(WORD_SHIFTS - 1)) begin
                    lane_d   = '0;
                    cursor_d = cursor_next_s;
                end else begin
                    lane_d   = lane_q + LANE_W'(1);
                end
                if (cnt_last_s) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ring_next_s[DATA_WIDTH-1:0];
                    ring_d      = write_q ? {ring_next_s[RING_BITS-1:DATA_WIDTH], wdata_q} : ring_next_s;
                end else begin
                    state_d = SHIFT;
                    ring_d  = ring_next_s;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            ring_q      <= '0;
            cursor_q    <= '0;
            lane_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            ring_q      <= ring_d;
            cursor_q    <= cursor_d;
            lane_q      <= lane_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign head          = ring_q[DATA_WIDTH-1:0];
    assign cursor        = cursor_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_shift_ring_controller.sv
// Self-checking bench for shift_ring_controller: directed vector table, corner sequences, random traffic vs. a memory model.
module tb_shift_ring_controller;
    localparam int DW        = 8;
    localparam int DEPTH     = 16;
    localparam int AW        = 4;
    localparam int LAT_LIMIT = 400;
`ifdef SHIFT_RING_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [31:0] lat_fwd;
        logic [31:0] lat_bidir;
    } vec_t;

    logic          clk;
    logic          rst;
    int unsigned   n_checks;
    int unsigned   n_fail;
    logic [DW-1:0] head0, head1;
    logic [AW-1:0] cur0, cur1;
    logic          busy0, busy1;

    shift_ring_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
    shift_ring_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

    shift_ring_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LANES(1)) u0 (
        .clk(clk), .rst(rst), .bus(b0), .head(head0), .cursor(cur0), .busy(busy0));
    shift_ring_controller #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LANES(4)) u1 (
        .clk(clk), .rst(rst), .bus(b1), .head(head1), .cursor(cur1), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain word array per instance plus the address last accessed
    logic [7:0]  mem [2][16];
    int unsigned mcur [2];
    logic [31:0] m_rd;
    logic [31:0] m_lat;

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            mcur[w] = 0;
            for (int a = 0; a < 16; a++) mem[w][a] = 8'h00;
        end
    endtask

    task automatic model_step(input int w, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        int unsigned steps, words, per_word;
        per_word = (w == 0) ? 8 : 2;
        steps    = (addr + 16 - mcur[w]) % 16;
        words    = (BIDIR && steps > 8) ? 16 - steps : steps;
        m_lat    = words * per_word + 1;
        m_rd     = {24'd0, mem[w][addr[3:0]]};
        if (wr) mem[w][addr[3:0]] = wd[7:0];
        mcur[w] = addr % 16;
    endtask

    function automatic logic [31:0] g_rsp_valid(input int w);
        return (w == 0) ? {31'd0, b0.rsp_valid} : {31'd0, b1.rsp_valid};
    endfunction
    function automatic logic [31:0] g_rdata(input int w);
        return (w == 0) ? {24'd0, b0.rsp_rdata} : {24'd0, b1.rsp_rdata};
    endfunction
    function automatic logic [31:0] g_ready(input int w);
        return (w == 0) ? {31'd0, b0.req_ready} : {31'd0, b1.req_ready};
    endfunction
    function automatic logic [31:0] g_busy(input int w);
        return (w == 0) ? {31'd0, busy0} : {31'd0, busy1};
    endfunction
    function automatic logic [31:0] g_cursor(input int w);
        return (w == 0) ? {28'd0, cur0} : {28'd0, cur1};
    endfunction
    function automatic logic [31:0] g_head(input int w);
        return (w == 0) ? {24'd0, head0} : {24'd0, head1};
    endfunction

    task automatic drive_req(input int w, input logic v, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        if (w == 0) begin
            b0.req_valid = v; b0.req_write = wr; b0.req_addr = addr[3:0]; b0.req_wdata = wd[7:0];
        end else begin
            b1.req_valid = v; b1.req_write = wr; b1.req_addr = addr[3:0]; b1.req_wdata = wd[7:0];
        end
    endtask

    task automatic set_rsp_ready(input int w, input logic v);
        if (w == 0) b0.rsp_ready = v;
        else        b1.rsp_ready = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input int w);
        check("rst_req_ready", g_ready(w), 32'd1);
        check("rst_busy", g_busy(w), 32'd0);
        check("rst_cursor", g_cursor(w), 32'd0);
        check("rst_rsp_valid", g_rsp_valid(w), 32'd0);
        check("rst_rsp_rdata", g_rdata(w), 32'd0);
        check("rst_head", g_head(w), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One transaction; latency counts edges from the accept edge until rsp_valid is seen
    task automatic txn(input int w, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, input logic [31:0] exp_rd,
                       output logic [31:0] rd, output logic [31:0] lat);
        @(negedge clk);
        drive_req(w, 1'b1, wr, addr, wd);
        @(posedge clk); #1;
        drive_req(w, 1'b0, 1'b0, 32'd0, 32'd0);
        check("busy_after_accept", g_busy(w), 32'd1);
        lat = 32'd1;
        while (g_rsp_valid(w) == 32'd0 && lat < LAT_LIMIT) begin
            @(posedge clk); #1;
            lat = lat + 32'd1;
        end
        rd = g_rdata(w);
        for (int i = 0; i < hold; i++) begin
            drive_req(w, (i % 2) == 0, ~wr, (addr + 32'd1) % 32'd16, 32'hFF);
            @(posedge clk); #1;
            check("hold_rsp_valid", g_rsp_valid(w), 32'd1);
            check("hold_rsp_rdata", g_rdata(w), exp_rd);
            check("hold_req_ready", g_ready(w), 32'd0);
            check("hold_cursor", g_cursor(w), addr);
        end
        drive_req(w, 1'b0, 1'b0, 32'd0, 32'd0);
        set_rsp_ready(w, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(w, 1'b0);
        check("rsp_valid_drop", g_rsp_valid(w), 32'd0);
    endtask

    task automatic run(input int w, input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] erd, elat, rd, lat;
        model_step(w, wr, addr, wd);
        erd  = m_rd;
        elat = m_lat;
        txn(w, wr, addr, wd, hold, erd, rd, lat);
        check("rdata", rd, erd);
        check("latency", lat, elat);
        check("cursor", g_cursor(w), addr);
        check("head", g_head(w), {24'd0, mem[w][addr[3:0]]});
        check("idle_req_ready", g_ready(w), 32'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [9];
        logic [31:0] rd, lat, a, r;
        int unsigned seen;

        vecs[0] = '{1'b0, 32'd5,  32'h00, 32'h00, 32'd41,  32'd41};
        vecs[1] = '{1'b1, 32'd3,  32'hA5, 32'h00, 32'd113, 32'd17};
        vecs[2] = '{1'b0, 32'd3,  32'h00, 32'hA5, 32'd1,   32'd1};
        vecs[3] = '{1'b1, 32'd3,  32'h3C, 32'hA5, 32'd1,   32'd1};
        vecs[4] = '{1'b0, 32'd3,  32'h00, 32'h3C, 32'd1,   32'd1};
        vecs[5] = '{1'b0, 32'd4,  32'h00, 32'h00, 32'd9,   32'd9};
        vecs[6] = '{1'b0, 32'd12, 32'h00, 32'h00, 32'd65,  32'd65};
        vecs[7] = '{1'b0, 32'd3,  32'h00, 32'h3C, 32'd57,  32'd57};
        vecs[8] = '{1'b0, 32'd12, 32'h00, 32'h00, 32'd73,  32'd57};

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_state(0);
        check_reset_state(1);

        // Directed table on the LANES=1 instance
        for (int i = 0; i < 9; i++) begin
            model_step(0, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wd, 0, vecs[i].exp_rd, rd, lat);
            check("vec_rdata", rd, vecs[i].exp_rd);
            check("vec_latency", lat, BIDIR ? vecs[i].lat_bidir : vecs[i].lat_fwd);
            check("vec_cursor", g_cursor(0), vecs[i].addr);
        end

        // LANES=4: two bits of a word per... four bits per cycle, two cycles per word
        model_step(1, 1'b0, 32'd2, 32'd0);
        txn(1, 1'b0, 32'd2, 32'd0, 0, 32'h00, rd, lat);
        check("lanes4_latency", lat, 32'd5);
        check("lanes4_rdata", rd, 32'h00);
        check("lanes4_cursor", g_cursor(1), 32'd2);
        run(1, 1'b1, 32'd2, 32'h5A, 0);
        run(1, 1'b0, 32'd7, 32'd0, 0);
        run(1, 1'b0, 32'd2, 32'd0, 0);

        // Fill every word, park at 0, then read the far end
        do_reset();
        check_reset_state(0);
        for (int n = 0; n < 16; n++) run(0, 1'b1, n, 32'h10 + n, 0);
        run(0, 1'b0, 32'd0, 32'd0, 0);
        model_step(0, 1'b0, 32'd15, 32'd0);
        txn(0, 1'b0, 32'd15, 32'd0, 0, 32'h1F, rd, lat);
        check("fill_rdata", rd, 32'h1F);
        check("fill_latency", lat, BIDIR ? 32'd9 : 32'd121);

        // Consumer stalls in RESP while decoy requests are offered
        run(0, 1'b0, 32'd6, 32'd0, 5);

        // Reset while a write is still rotating
        a = (mcur[0] + 10) % 16;
        @(negedge clk);
        drive_req(0, 1'b1, 1'b1, a, 32'hEE);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_still_shifting", g_busy(0), 32'd1);
        do_reset();
        check_reset_state(0);
        check_reset_state(1);
        seen = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (b0.rsp_valid) seen++;
        end
        check("no_rsp_after_abort", seen, 32'd0);
        for (int n = 0; n < 16; n++) run(0, 1'b0, n, 32'd0, 0);

        // Random traffic on both instances against the model
        for (int i = 0; i < 80; i++) begin
            r = $urandom;
            run(i % 2, r[0], {28'd0, r[7:4]}, {24'd0, r[15:8]}, int'(r[17:16]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
